// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - data-memory load/store sequencer with unaligned split and read-modify-write
module load_store_unit #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        isLoad,
    input  logic        isStore,
    input  logic [31:0] aluResult,
    input  logic [31:0] writeDataMem,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [31:0] readData,
    output logic [31:0] memAddr,
    output logic [31:0] memWriteData,
    output logic        MemRead,
    output logic        MemWrite,
    input  logic        memReady,
    input  logic [31:0] memReadData
);
    typedef enum logic [2:0] {IDLE, RD0, RD1, WR0, WR1, GAP, FIN} state_t;
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t      state, state_nx, after_gap, after_gap_nx;
    logic [31:0] addr0, addr1, store_data, w0, w1;
    logic [31:0] load_result, merge0, merge1;
    logic [1:0]  lane;
    logic        is_load, err, unaligned, access, timed_out;
    logic [7:0]  wait_cnt;
    logic [5:0]  sh, rsh;

    assign addr1     = addr0 + 32'd4;
    assign unaligned = lane != 2'd0;
    assign sh        = {1'b0, lane, 3'b000};
    assign rsh       = 6'd32 - sh;

    // Big-endian byte lanes: the first addressed byte lands in readData[31:24].
    assign load_result = unaligned ? ((w0 << sh) | (w1 >> rsh)) : w0;
    assign merge0      = unaligned ? ((w0 & ~(32'hFFFFFFFF >> sh)) | (store_data >> sh)) : store_data;
    assign merge1      = (w1 & ~(32'hFFFFFFFF << rsh)) | (store_data << rsh);

    assign access    = (state == RD0) || (state == RD1) || (state == WR0) || (state == WR1);
    assign timed_out = access && !memReady && (wait_cnt == WAIT_LAST);

    assign busy  = (state != IDLE) && (state != FIN);
    assign done  = state == FIN;
    assign error = (state == FIN) && err;

    always_comb begin
        state_nx     = state;
        after_gap_nx = after_gap;
        memAddr      = 32'd0;
        memWriteData = 32'd0;
        MemRead      = 1'b0;
        MemWrite     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (isLoad == isStore)
                        state_nx = FIN;
                    else if (isLoad || (aluResult[1:0] != 2'd0))
                        state_nx = RD0;
                    else
                        state_nx = WR0;
                end
            end
            RD0: begin
                MemRead = 1'b1;
                memAddr = addr0;
                if (memReady) begin
                    state_nx     = GAP;
                    after_gap_nx = unaligned ? RD1 : FIN;
                end else if (timed_out) begin
                    state_nx = FIN;
                end
            end
            RD1: begin
                MemRead = 1'b1;
                memAddr = addr1;
                if (memReady) begin
                    state_nx     = GAP;
                    after_gap_nx = is_load ? FIN : WR0;
                end else if (timed_out) begin
                    state_nx = FIN;
                end
            end
            WR0: begin
                MemWrite     = 1'b1;
                memAddr      = addr0;
                memWriteData = merge0;
                if (memReady) begin
                    state_nx     = GAP;
                    after_gap_nx = unaligned ? WR1 : FIN;
                end else if (timed_out) begin
                    state_nx = FIN;
                end
            end
            WR1: begin
                MemWrite     = 1'b1;
                memAddr      = addr1;
                memWriteData = merge1;
                if (memReady) begin
                    state_nx     = GAP;
                    after_gap_nx = FIN;
                end else if (timed_out) begin
                    state_nx = FIN;
                end
            end
            GAP:     state_nx = after_gap;
            FIN:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            after_gap  <= IDLE;
            addr0      <= 32'd0;
            store_data <= 32'd0;
            lane       <= 2'd0;
            is_load    <= 1'b0;
            err        <= 1'b0;
            w0         <= 32'd0;
            w1         <= 32'd0;
            wait_cnt   <= 8'd0;
            readData   <= 32'd0;
        end else begin
            state     <= state_nx;
            after_gap <= after_gap_nx;
            wait_cnt  <= (access && (state_nx == state)) ? wait_cnt + 8'd1 : 8'd0;
            if ((state == IDLE) && start) begin
                addr0      <= {aluResult[31:2], 2'b00};
                lane       <= aluResult[1:0];
                store_data <= writeDataMem;
                is_load    <= isLoad;
                err        <= isLoad == isStore;
            end
            if (timed_out)
                err <= 1'b1;
            if ((state == RD0) && memReady)
                w0 <= memReadData;
            if ((state == RD1) && memReady)
                w1 <= memReadData;
            // Timed-out commands never pass through GAP, so readData keeps its old value.
            if ((state == GAP) && (after_gap == FIN) && is_load)
                readData <= load_result;
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - randomized scoreboard bench for load_store_unit against a byte-level memory model
module tb_load_store_unit;
    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, isLoad, isStore;
    logic [31:0] aluResult, writeDataMem;
    logic        busy, done, error;
    logic [31:0] readData, memAddr, memWriteData;
    logic        MemRead, MemWrite;
    logic        memReady = 1'b0;
    logic [31:0] memReadData = 32'd0;

    load_store_unit #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .isLoad(isLoad), .isStore(isStore),
        .aluResult(aluResult), .writeDataMem(writeDataMem), .busy(busy), .done(done),
        .error(error), .readData(readData), .memAddr(memAddr), .memWriteData(memWriteData),
        .MemRead(MemRead), .MemWrite(MemWrite), .memReady(memReady), .memReadData(memReadData)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; bit wr; logic [31:0] data; } acc_t;
    typedef struct { bit err; logic [31:0] rd; } cmp_t;

    acc_t        acc_q[$];
    cmp_t        done_q[$];
    logic [31:0] mem[logic [31:0]];
    logic [31:0] ref_mem[logic [31:0]];
    logic [31:0] model_rd = 32'd0;
    int nchecks = 0, nerrors = 0, cyc = 0, acc_cnt = 0, hang_at = 255;
    int fixed_lat = -1, lat = 0, req_cycles = 0, last_ack_cyc = 0;
    bit req_prev = 1'b0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerrors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5AC3C3;
    endfunction

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : init_word(a);
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    task automatic preload(input logic [31:0] a, input logic [31:0] w);
        mem[a] = w;
        ref_mem[a] = w;
    endtask

    // Reference: the command as four byte accesses at a..a+3 on a byte-addressed big-endian memory.
    task automatic model(input logic [31:0] a, input logic [31:0] d, input bit ld, input bit st, input int hang);
        acc_t        list[$];
        acc_t        e;
        cmp_t        c;
        logic [31:0] a0, a1, ba, w, nw0, nw1, res;
        int          lane;
        bit          err;
        err = (ld == st);
        a0  = a & 32'hFFFFFFFC;
        a1  = a0 + 32'd4;
        res = 32'd0;
        if (!err) begin
            e.wr = 1'b0;
            e.data = 32'd0;
            if (ld || (a[1:0] != 2'd0)) begin
                e.addr = a0;
                list.push_back(e);
                if (a[1:0] != 2'd0) begin
                    e.addr = a1;
                    list.push_back(e);
                end
            end
            if (st) begin
                nw0 = ref_rd(a0);
                nw1 = ref_rd(a1);
                for (int i = 0; i < 4; i++) begin
                    ba = a + 32'(i);
                    lane = int'(ba[1:0]);
                    if ((ba & 32'hFFFFFFFC) == a0) nw0[31-8*lane -: 8] = d[31-8*i -: 8];
                    else nw1[31-8*lane -: 8] = d[31-8*i -: 8];
                end
                e.wr = 1'b1;
                e.addr = a0;
                e.data = nw0;
                list.push_back(e);
                if (a[1:0] != 2'd0) begin
                    e.addr = a1;
                    e.data = nw1;
                    list.push_back(e);
                end
            end else begin
                for (int i = 0; i < 4; i++) begin
                    ba = a + 32'(i);
                    lane = int'(ba[1:0]);
                    w = ref_rd(ba & 32'hFFFFFFFC);
                    res[31-8*i -: 8] = w[31-8*lane -: 8];
                end
            end
            if (hang < list.size()) begin
                err = 1'b1;
                while (list.size() > hang) void'(list.pop_back());
            end else if (ld) begin
                model_rd = res;
            end
        end
        foreach (list[j]) begin
            acc_q.push_back(list[j]);
            if (list[j].wr) ref_mem[list[j].addr] = list[j].data;
        end
        c.err = err;
        c.rd  = model_rd;
        done_q.push_back(c);
    endtask

    // Memory responder: random latency, optional hang, idle-time memReady noise; checks each access.
    always @(negedge clk) begin
        acc_t e;
        bit   req;
        if (!rst_n) begin
            memReady = 1'b0;
            req_prev = 1'b0;
        end else begin
            req = MemRead || MemWrite;
            if (req && !req_prev) begin
                lat = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
                check("single_request_kind", {31'd0, MemRead && MemWrite}, 32'd0);
                check("addr_aligned", {30'd0, memAddr[1:0]}, 32'd0);
                if (acc_cnt > 0) check("gap_cycles", 32'(cyc - last_ack_cyc), 32'd2);
            end
            if (req && (lat == 0) && (acc_cnt < hang_at)) begin
                memReady = 1'b1;
                check("access_expected", 32'(acc_q.size() != 0), 32'd1);
                if (acc_q.size() != 0) begin
                    e = acc_q.pop_front();
                    check("acc_addr", memAddr, e.addr);
                    check("acc_is_write", {31'd0, MemWrite}, {31'd0, e.wr});
                    if (e.wr) check("acc_wdata", memWriteData, e.data);
                end
                if (MemWrite) mem[memAddr] = memWriteData;
                memReadData = mem_rd(memAddr);
                acc_cnt++;
                last_ack_cyc = cyc;
            end else if (req) begin
                memReady = 1'b0;
                if (lat > 0) lat--;
            end else begin
                memReady = ($urandom_range(0, 3) == 0);
                memReadData = $urandom;
            end
            req_prev = req;
        end
    end

    always @(negedge clk) begin
        cmp_t c;
        if (rst_n && error) check("error_implies_done", {31'd0, done}, 32'd1);
        if (rst_n && done) begin
            check("done_expected", 32'(done_q.size() != 0), 32'd1);
            if (done_q.size() != 0) begin
                c = done_q.pop_front();
                check("done_error", {31'd0, error}, {31'd0, c.err});
                check("read_data", readData, c.rd);
                check("accesses_complete", 32'(acc_q.size()), 32'd0);
                check("busy_low_in_fin", {31'd0, busy}, 32'd0);
            end
        end
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] d, input bit ld, input bit st, input int hang);
        int cycles;
        model(a, d, ld, st, hang);
        acc_cnt = 0;
        hang_at = hang;
        @(negedge clk);
        start = 1'b1;
        aluResult = a;
        writeDataMem = d;
        isLoad = ld;
        isStore = st;
        @(negedge clk);
        if (ld == st) check("illegal_done_next_cycle", {31'd0, done}, 32'd1);
        else check("busy_after_accept", {31'd0, busy}, 32'd1);
        cycles = 0;
        req_cycles = 0;
        while (!done && cycles < 400) begin
            if (MemRead || MemWrite) req_cycles++;
            start = ($urandom_range(0, 3) == 0);
            aluResult = $urandom;
            writeDataMem = $urandom;
            isLoad = 1'($urandom_range(0, 1));
            isStore = 1'($urandom_range(0, 1));
            @(negedge clk);
            cycles++;
        end
        check("done_within_bound", {31'd0, done}, 32'd1);
        start = 1'b1;
        aluResult = $urandom;
        isLoad = 1'b1;
        isStore = 1'b0;
        @(negedge clk);
        start = 1'b0;
        check("start_in_fin_ignored", {31'd0, busy | done}, 32'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        acc_t e;
        int   cycles;
        start = 1'b0; isLoad = 1'b0; isStore = 1'b0;
        aluResult = 32'd0; writeDataMem = 32'd0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_error", {31'd0, error}, 32'd0);
        check("rst_memread", {31'd0, MemRead}, 32'd0);
        check("rst_memwrite", {31'd0, MemWrite}, 32'd0);
        check("rst_memaddr", memAddr, 32'd0);
        check("rst_memwritedata", memWriteData, 32'd0);
        check("rst_readdata", readData, 32'd0);
        rst_n = 1'b1;

        preload(32'h100, 32'hDEADBEEF);
        fixed_lat = 3;
        issue(32'h100, 32'd0, 1'b1, 1'b0, 255);
        check("aligned_load", readData, 32'hDEADBEEF);
        fixed_lat = -1;

        preload(32'h100, 32'h11223344);
        preload(32'h104, 32'h55667788);
        issue(32'h102, 32'd0, 1'b1, 1'b0, 255);
        check("unaligned_load", readData, 32'h33445566);

        issue(32'h101, 32'hAABBCCDD, 1'b0, 1'b1, 255);
        check("rmw_word0", mem_rd(32'h100), 32'h11AABBCC);
        check("rmw_word1", mem_rd(32'h104), 32'hDD667788);

        preload(32'hFFFFFFFC, 32'h01020304);
        preload(32'h0, 32'hA0B0C0D0);
        issue(32'hFFFFFFFF, 32'd0, 1'b1, 1'b0, 255);
        check("wrap_load", readData, 32'h04A0B0C0);

        issue(32'h200, 32'd0, 1'b1, 1'b0, 0);
        check("timeout_request_cycles", 32'(req_cycles), 32'(TO));
        check("timeout_readdata_kept", readData, 32'h04A0B0C0);

        issue(32'h300, 32'h12345678, 1'b1, 1'b1, 255);
        issue(32'h300, 32'h12345678, 1'b0, 1'b0, 255);

        // Reset while the second read of an unaligned load is outstanding.
        e.addr = 32'h120; e.wr = 1'b0; e.data = 32'd0;
        acc_q.push_back(e);
        acc_cnt = 0;
        hang_at = 1;
        @(negedge clk);
        start = 1'b1; aluResult = 32'h122; isLoad = 1'b1; isStore = 1'b0;
        @(negedge clk);
        start = 1'b0;
        cycles = 0;
        while (!(MemRead && memAddr == 32'h124) && cycles < 50) begin
            @(negedge clk);
            cycles++;
        end
        check("reached_second_read", {31'd0, MemRead && (memAddr == 32'h124)}, 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_memread", {31'd0, MemRead}, 32'd0);
        check("midrst_memwrite", {31'd0, MemWrite}, 32'd0);
        check("midrst_memaddr", memAddr, 32'd0);
        check("midrst_memwritedata", memWriteData, 32'd0);
        check("midrst_readdata", readData, 32'd0);
        check("midrst_done", {31'd0, done}, 32'd0);
        check("midrst_first_read_done", 32'(acc_q.size()), 32'd0);
        repeat (3) @(negedge clk);
        model_rd = 32'd0;
        hang_at = 255;
        rst_n = 1'b1;

        for (int k = 0; k < 200; k++) begin
            logic [31:0] a;
            int          r, h;
            bit          ld, st;
            a = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFF8 + $urandom_range(0, 7)
                                             : 32'h100 + $urandom_range(0, 31);
            r = $urandom_range(0, 9);
            if (r == 0) begin
                ld = 1'($urandom_range(0, 1));
                st = ld;
            end else if (r <= 5) begin
                ld = 1'b1;
                st = 1'b0;
            end else begin
                ld = 1'b0;
                st = 1'b1;
            end
            h = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 3)) : 255;
            issue(a, $urandom, ld, st, h);
        end

        repeat (5) @(negedge clk);
        check("scoreboard_drained", 32'(done_q.size() + acc_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", nchecks, nerrors);
        $finish;
    end
endmodule
